// File: rtl/score_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : score_scan_controller
// Purpose  : Walks the one-cycle score decoder across the 16 tiles of a 2048
//            board. It accumulates the decoded tile values into a board score
//            and tracks the highest legal tile code, the win flag and the
//            number of empty tiles.
// Options  : SCORE_EMPTY_CNT_EN - when defined, empty_cnt counts code-0 tiles.
//            When it is undefined, the counter is omitted and empty_cnt is
//            tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module score_scan_controller #(
  parameter int SCORE_W   = 20,
  parameter int WIN_LEVEL = 11
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               start,
  input  logic [63:0]        board,
  output logic               dec_en,
  output logic [3:0]         dec_state,
  input  logic [15:0]        dec_value,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         max_tile,
  output logic               win,
  output logic [4:0]         empty_cnt
);

  localparam int         c_pad       = SCORE_W - 16;
  localparam logic [3:0] c_win_level = WIN_LEVEL[3:0];
  localparam logic [3:0] c_illegal   = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [63:0]        r_board;
  logic [3:0]         r_idx;
  logic [SCORE_W-1:0] r_acc;
  logic [3:0]         r_max;
  logic               r_vld;
  logic               r_dec_en;
  logic               r_busy;
  logic               r_done;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_max_tile;
  logic               r_win;

  logic [3:0]         w_code;
  logic [SCORE_W-1:0] w_dec_ext;
  logic [SCORE_W-1:0] w_acc_next;

  // Select the tile under the scan index from the latched board copy.
  assign w_code     = r_board[{r_idx, 2'b00} +: 4];
  assign w_dec_ext  = {{c_pad{1'b0}}, dec_value};
  // The decoder result is used only in the cycle after an issue.
  assign w_acc_next = r_acc + (r_vld ? w_dec_ext : '0);

  assign dec_en    = r_dec_en;
  assign dec_state = (r_state == S_ISSUE) ? w_code : 4'd0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign score     = r_score;
  assign max_tile  = r_max_tile;
  assign win       = r_win;

  // Scan sequencer: issue 16 tiles, drain the last decode, then publish the results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_board    <= 64'd0;
      r_idx      <= 4'd0;
      r_acc      <= '0;
      r_max      <= 4'd0;
      r_vld      <= 1'b0;
      r_dec_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_score    <= '0;
      r_max_tile <= 4'd0;
      r_win      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= r_dec_en;
      r_acc  <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_board  <= board;
            r_acc    <= '0;
            r_max    <= 4'd0;
            r_idx    <= 4'd0;
            r_dec_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_idx <= r_idx + 4'd1;
          // Code 15 is illegal, so it never counts toward the maximum.
          if ((w_code != c_illegal) && (w_code > r_max)) begin
            r_max <= w_code;
          end
          if (r_idx == 4'd15) begin
            r_dec_en <= 1'b0;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The final tile's value is added here, so publish the sum including it.
          r_score    <= w_acc_next;
          r_max_tile <= r_max;
          r_win      <= (r_max >= c_win_level);
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SCORE_EMPTY_CNT_EN
  logic [4:0] r_empty;
  logic [4:0] r_empty_cnt;

  // Count empty tiles during the scan and publish the count with the other results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_empty     <= 5'd0;
      r_empty_cnt <= 5'd0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_empty <= 5'd0;
      end else if ((r_state == S_ISSUE) && (w_code == 4'd0)) begin
        r_empty <= r_empty + 5'd1;
      end
      if (r_state == S_DRAIN) begin
        r_empty_cnt <= r_empty;
      end
    end
  end

  assign empty_cnt = r_empty_cnt;
`else
  assign empty_cnt = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_scan_controller
// Purpose  : Scoreboard bench for score_scan_controller. The stimulus pushes
//            the expected results, and a done-driven monitor pops them and
//            compares them against the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_scan_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] board;
  logic        dec_en;
  logic [3:0]  dec_state;
  logic [15:0] dec_value;
  logic        busy;
  logic        done;
  logic [19:0] score;
  logic [3:0]  max_tile;
  logic        win;
  logic [4:0]  empty_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [19:0] s;
    logic [3:0]  m;
    logic        w;
    logic [4:0]  e;
    int          c;
  } exp_t;

  exp_t sb[$];

  score_scan_controller #(.SCORE_W(20), .WIN_LEVEL(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board     (board),
    .dec_en    (dec_en),
    .dec_state (dec_state),
    .dec_value (dec_value),
    .busy      (busy),
    .done      (done),
    .score     (score),
    .max_tile  (max_tile),
    .win       (win),
    .empty_cnt (empty_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decoder: 2^code for legal nonzero codes, with a one-cycle
  // latency. Junk is driven when not enabled.
  function automatic logic [15:0] dec_f(input logic [3:0] code);
    if (code == 4'd0 || code == 4'd15) return 16'd0;
    return 16'd1 << code;
  endfunction

  always @(posedge clk) dec_value <= dec_en ? dec_f(dec_state) : 16'hA5A5;

  function automatic logic [4:0] exp_empty(input logic [4:0] e);
`ifdef SCORE_EMPTY_CNT_EN
    return e;
`else
    return 5'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.c);
        chk("score", {12'd0, score}, {12'd0, e.s});
        chk("max_tile", {28'd0, max_tile}, {28'd0, e.m});
        chk("win", {31'd0, win}, {31'd0, e.w});
        chk("empty_cnt", {27'd0, empty_cnt}, {27'd0, e.e});
      end
    end
  end

  // Runs one scan and checks busy, dec_en and dec_state in every cycle.
  // When repulse is set, start is pulsed again in C5 and in C18.
  task automatic run_scan(input logic [63:0] b, input logic [19:0] s, input logic [3:0] m,
                          input logic w, input logic [4:0] e, input bit repulse);
    exp_t x;
    @(negedge clk);
    board = b;
    start = 1'b1;
    x.s = s; x.m = m; x.w = w; x.e = exp_empty(e); x.c = cyc + 18;
    sb.push_back(x);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) board = ~b;
      chk("busy", {31'd0, busy}, {31'd0, (i <= 18)});
      chk("dec_en", {31'd0, dec_en}, {31'd0, (i <= 16)});
      if (i <= 16) chk("dec_state", {28'd0, dec_state}, {28'd0, b[4*(i-1) +: 4]});
      if (repulse && (i == 5 || i == 18)) start = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    board = 64'd0;
    dec_value = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dec_en", {31'd0, dec_en}, 32'd0);
    chk("rst_dec_state", {28'd0, dec_state}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_score", {12'd0, score}, 32'd0);
    chk("rst_max_tile", {28'd0, max_tile}, 32'd0);
    chk("rst_win", {31'd0, win}, 32'd0);
    chk("rst_empty", {27'd0, empty_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_scan(64'h0000_0000_0000_0000, 20'd0,      4'd0,  1'b0, 5'd16, 1'b0);
    run_scan(64'h1111_1111_1111_1111, 20'd32,     4'd1,  1'b0, 5'd0,  1'b0);
    run_scan(64'h0000_0000_00E0_000B, 20'd18432,  4'd14, 1'b1, 5'd14, 1'b0);
    run_scan(64'hEEEE_EEEE_EEEE_EEEE, 20'd262144, 4'd14, 1'b1, 5'd0,  1'b0);
    run_scan(64'h0000_0000_0000_F000, 20'd0,      4'd0,  1'b0, 5'd15, 1'b0);
    run_scan(64'h0000_0000_0000_00A0, 20'd1024,   4'd10, 1'b0, 5'd15, 1'b0);
    run_scan(64'hB000_0000_0000_0000, 20'd2048,   4'd11, 1'b1, 5'd15, 1'b1);

    // Abort a scan by asserting reset in C9.
    @(negedge clk);
    board = 64'h1111_1111_1111_1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dec_en", {31'd0, dec_en}, 32'd0);
    chk("abort_score", {12'd0, score}, 32'd0);
    chk("abort_max_tile", {28'd0, max_tile}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done_score", {12'd0, score}, 32'd0);

    run_scan(64'h0000_0000_00E0_000B, 20'd18432, 4'd14, 1'b1, 5'd14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
